ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction-fetch front end for the mips789 core. It takes the fetch address from the PC register, issues one read at a time to instruction memory over a request/grant/response handshake, and holds the returned word for the decode stage. It raises a pause request back to `pc_gen` and the pipeline while a fetch is outstanding. It also handles redirects (flush), misaligned addresses and unresponsive memory.

## Interface
- `TIMEOUT`, 255: number of cycles in WAIT without `mem_rvalid_i` before the fetch is abandoned (1..255).
- `clock`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `pc_i`  in  32  address to fetch (PC register output).
- `pc_vld_i`  in  1  core requests fetch of `pc_i`.
- `flush_i`  in  1  redirect; discard any in-flight or held instruction.
- `pause_i`  in  1  decode stall; held instruction not consumed this cycle.
- `mem_req_o`  out  1  read request to instruction memory.
- `mem_addr_o`  out  32  word-aligned read address.
- `mem_gnt_i`  in  1  memory accepted the request this cycle.
- `mem_rvalid_i`  in  1  read data valid.
- `mem_rdata_i`  in  32  read data.
- `ins_o`  out  32  fetched instruction.
- `ins_pc_o`  out  32  address of `ins_o`.
- `ins_vld_o`  out  1  `ins_o`/`ins_pc_o` valid.
- `stall_o`  out  1  pause request to `pc_gen`/pipeline (combinational).
- `err_o`  out  1  one-cycle pulse: misaligned PC or timeout.

## Operation
- States: IDLE, REQ, WAIT, VALID. Internal: `drop` flag, 8-bit `wait_cnt`.
- IDLE:
  - `pc_vld_i` with `pc_i[1:0]==0` and `drop==0`: latch `pc_i` into `mem_addr_o` and go to REQ.
  - `pc_vld_i` with `pc_i[1:0]!=0`: `err_o`=1 in the next cycle, no request issued, stay IDLE.
- REQ:
  - `mem_req_o`=1 with `mem_addr_o` stable until `mem_gnt_i`. A request is never retracted, including on flush.
  - On `mem_gnt_i`: go to WAIT and clear `wait_cnt`.
  - `flush_i` in REQ sets `drop`.
- WAIT:
  - `mem_rvalid_i` with `drop==0` and no `flush_i`: capture `ins_o`=`mem_rdata_i` and `ins_pc_o`=`mem_addr_o`, go to VALID.
  - `mem_rvalid_i` with `drop` set, or with `flush_i` in the same cycle: discard the data, clear `drop`, go to IDLE.
  - `flush_i` alone: set `drop` and stay in WAIT.
  - `wait_cnt` reaches `TIMEOUT-1` with no `mem_rvalid_i`: `err_o` pulse, set `drop`, go to IDLE.
- `drop` handling in IDLE: while `drop`=1, no new request is issued. Any `mem_rvalid_i` clears `drop` and its data is ignored.
- VALID:
  - `ins_vld_o`=1 and the instruction is held.
  - `flush_i`: go to IDLE, `ins_vld_o` drops.
  - `pause_i`=0: the instruction is consumed. If `pc_vld_i` is high with an aligned PC, go directly to REQ with the new address; otherwise go to IDLE.
  - `pause_i`=1: hold.
- `stall_o`=1 except in two cases:
  - IDLE with `pc_vld_i`=0;
  - VALID with `pause_i`=0 and `flush_i`=0.
- Protocol: memory never asserts `mem_rvalid_i` in the grant cycle or while no request is outstanding. Memory is reset by the same `rst`.

## Timing
- Reset values: state IDLE; `mem_req_o` 0, `mem_addr_o` 0, `ins_o` 0, `ins_pc_o` 0, `ins_vld_o` 0, `err_o` 0. `drop` 0, `wait_cnt` 0.
- Reset mid-fetch abandons everything; the next cycle is IDLE.
- Minimum latency with zero-wait memory:
  - `pc_vld_i` at cycle 0;
  - `mem_req_o` at cycle 1, granted at cycle 1;
  - `mem_rvalid_i` at cycle 2;
  - `ins_vld_o` at cycle 3.
- Peak throughput is one instruction per 3 cycles (VALID→REQ back-to-back).
- `err_o` is registered and lasts exactly one cycle.
- `flush_i` has priority over `pause_i`, `mem_rvalid_i` and a new `pc_vld_i` in the same cycle.

## Test plan
- Basic fetch: `pc_i`=0x0000_0040, zero-wait memory returning 0x2408_0005 → `mem_addr_o`=0x40 at cycle 1, `ins_vld_o`=1 at cycle 3 with `ins_o`=0x2408_0005, `ins_pc_o`=0x40.
- Grant delay plus pause: `mem_gnt_i` delayed 4 cycles, `pause_i`=1 for 3 cycles after valid → `mem_req_o` and `mem_addr_o` stay stable; the instruction is held 3 cycles; `stall_o`=1 throughout the pause.
- Flush in WAIT: flush after grant, then `mem_rvalid_i` with 0xDEAD_BEEF → data discarded, `ins_vld_o` stays 0. The next `pc_vld_i` at 0x80 produces a request only after the discarded response.
- Misaligned PC: `pc_i`=0x0000_0042 → one-cycle `err_o`, no `mem_req_o`, `ins_vld_o` stays 0.
- Timeout: `TIMEOUT`=8, no `mem_rvalid_i` → `err_o` pulse at the 8th WAIT cycle, then IDLE. A late response is dropped.
- Back-to-back: PCs 0x0, 0x4, 0x8 with `pause_i`=0 → three `ins_vld_o` pulses spaced 3 cycles apart. Reset asserted during the second fetch leaves all outputs 0.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: one outstanding read to instruction memory,
// holds the returned word for decode and handles flush, misalignment and timeout.
module ifetch_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        pc_vld_i,
    input  logic        flush_i,
    input  logic        pause_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] ins_o,
    output logic [31:0] ins_pc_o,
    output logic        ins_vld_o,
    output logic        stall_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        VALID = 2'd3
    } state_e;

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] ins_q, ins_d;
    logic [31:0] ipc_q, ipc_d;
    logic        err_q, err_d;
    logic        drop_q, drop_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        aligned;

    assign aligned = (pc_i[1:0] == 2'b00);

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            ins_q   <= '0;
            ipc_q   <= '0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ins_q   <= ins_d;
            ipc_q   <= ipc_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ins_d   = ins_q;
        ipc_d   = ipc_q;
        err_d   = 1'b0;
        drop_d  = drop_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                // A stale response still owed after flush/timeout releases drop
                if (mem_rvalid_i) drop_d = 1'b0;
                if (!flush_i && pc_vld_i) begin
                    if (!aligned) begin
                        err_d = 1'b1;
                    end else if (!drop_q) begin
                        state_d = REQ;
                        addr_d  = pc_i;
                    end
                end
            end
            REQ: begin
                if (flush_i) drop_d = 1'b1;
                if (mem_gnt_i) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    drop_d = 1'b0;
                    if (drop_q || flush_i) begin
                        state_d = IDLE;
                    end else begin
                        state_d = VALID;
                        ins_d   = mem_rdata_i;
                        ipc_d   = addr_q;
                    end
                end else if (cnt_q == CntLast) begin
                    err_d   = 1'b1;
                    drop_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    if (flush_i) drop_d = 1'b1;
                    cnt_d = cnt_q + 8'd1;
                end
            end
            VALID: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (!pause_i) begin
                    state_d = IDLE;
                    if (pc_vld_i) begin
                        if (!aligned) begin
                            err_d = 1'b1;
                        end else begin
                            state_d = REQ;
                            addr_d  = pc_i;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req_o  = (state_q == REQ);
        mem_addr_o = addr_q;
        ins_o      = ins_q;
        ins_pc_o   = ipc_q;
        ins_vld_o  = (state_q == VALID);
        err_o      = err_q;
        stall_o    = 1'b1;
        if (state_q == IDLE && !pc_vld_i) stall_o = 1'b0;
        if (state_q == VALID && !pause_i && !flush_i) stall_o = 1'b0;
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios with literal expectations, then
// random traffic checked every cycle against a transaction-level model.
module tb_ifetch_unit;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_i = '0;
    logic        pc_vld_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        pause_i = 1'b0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic [31:0] ins_o;
    logic [31:0] ins_pc_o;
    logic        ins_vld_o;
    logic        stall_o;
    logic        err_o;

    ifetch_unit #(.TIMEOUT(TO)) dut (
        .clock(clk), .rst(rst),
        .pc_i(pc_i), .pc_vld_i(pc_vld_i),
        .flush_i(flush_i), .pause_i(pause_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i),
        .ins_o(ins_o), .ins_pc_o(ins_pc_o), .ins_vld_o(ins_vld_o),
        .stall_o(stall_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit armed = 0;

    // memory responder
    bit          rnd = 0;
    bit          pend = 0;
    int          mcnt = 0;
    int          req_age = 0;
    int          gnt_wait = 0;
    int          lat = 1;
    logic [31:0] rdat = '0;

    // reference model: transaction view of the fetch unit
    bit          m_req = 0, m_wait = 0, m_vld = 0, m_err = 0, m_drop = 0;
    logic [31:0] m_addr = '0, m_ins = '0, m_ipc = '0;
    int          m_waited = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit pv, input logic [31:0] pc,
                        input bit fl, input bit pa);
        bit          gnt, rv, od, n_err, iss, idle, exp_stall;
        logic [31:0] rd;
        @(negedge clk);
        if (armed) begin
            chk("mem_req", {31'd0, mem_req_o}, {31'd0, m_req});
            chk("mem_addr", mem_addr_o, m_addr);
            chk("ins_vld", {31'd0, ins_vld_o}, {31'd0, m_vld});
            chk("ins", ins_o, m_ins);
            chk("ins_pc", ins_pc_o, m_ipc);
            chk("err", {31'd0, err_o}, {31'd0, m_err});
        end
        gnt = 0;
        rv  = 0;
        rd  = $urandom;
        if (r) begin
            pend    = 0;
            req_age = 0;
        end else begin
            if (pend) begin
                mcnt--;
                if (mcnt == 0) begin
                    rv   = 1;
                    pend = 0;
                    rd   = rnd ? $urandom : rdat;
                end
            end
            if (mem_req_o === 1'b1 && !pend) begin
                if (rnd) begin
                    gnt = ($urandom_range(0, 2) != 0);
                    if ($urandom_range(0, 7) == 0) lat = $urandom_range(5, 14);
                    else lat = $urandom_range(1, 3);
                end else begin
                    gnt = (req_age >= gnt_wait);
                end
                if (gnt) begin
                    pend    = 1;
                    mcnt    = lat;
                    req_age = 0;
                end else begin
                    req_age++;
                end
            end
        end
        rst          = r;
        pc_vld_i     = pv;
        pc_i         = pc;
        flush_i      = fl;
        pause_i      = pa;
        mem_gnt_i    = gnt;
        mem_rvalid_i = rv;
        mem_rdata_i  = rd;
        #1;
        idle = !m_req && !m_wait && !m_vld;
        exp_stall = !((idle && !pv) || (m_vld && !pa && !fl));
        if (armed && !r) chk("stall", {31'd0, stall_o}, {31'd0, exp_stall});
        od    = m_drop;
        n_err = 0;
        iss   = 0;
        if (r) begin
            m_req = 0; m_wait = 0; m_vld = 0; m_drop = 0;
            m_addr = '0; m_ins = '0; m_ipc = '0; m_waited = 0;
        end else if (m_req) begin
            if (fl) m_drop = 1;
            if (gnt) begin
                m_req    = 0;
                m_wait   = 1;
                m_waited = 0;
            end
        end else if (m_wait) begin
            if (rv) begin
                m_wait = 0;
                m_drop = 0;
                if (!(od || fl)) begin
                    m_vld = 1;
                    m_ins = rd;
                    m_ipc = m_addr;
                end
            end else if (m_waited == TO - 1) begin
                n_err  = 1;
                m_drop = 1;
                m_wait = 0;
            end else begin
                if (fl) m_drop = 1;
                m_waited++;
            end
        end else if (m_vld) begin
            if (fl) m_vld = 0;
            else if (!pa) begin
                m_vld = 0;
                iss   = 1;
            end
        end else begin
            if (rv) m_drop = 0;
            if (!fl) iss = 1;
        end
        if (iss && pv) begin
            if (pc[1:0] != 2'b00) n_err = 1;
            else if (!od) begin
                m_req  = 1;
                m_addr = pc;
            end
        end
        m_err = n_err;
        armed = 1;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, 0, 0);
    endtask

    initial begin
        logic [31:0] pc;
        step(1, 0, 32'h0, 0, 0);

        // basic fetch, zero-wait memory
        gnt_wait = 0; lat = 1; rdat = 32'h2408_0005;
        step(0, 1, 32'h40, 0, 0);
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_vld", {31'd0, ins_vld_o}, 32'd0);
        step(0, 0, 32'h0, 0, 0);
        chk("b_req", {31'd0, mem_req_o}, 32'd1);
        chk("b_addr", mem_addr_o, 32'h40);
        step(0, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        chk("b_vld", {31'd0, ins_vld_o}, 32'd1);
        chk("b_ins", ins_o, 32'h2408_0005);
        chk("b_pc", ins_pc_o, 32'h40);
        chk("b_stall", {31'd0, stall_o}, 32'd0);
        idle_n(2);

        // grant delayed 4 cycles, then pause 3 cycles
        gnt_wait = 4; rdat = 32'h1234_5678;
        step(0, 1, 32'h44, 0, 0);
        idle_n(2);
        step(0, 0, 32'h0, 0, 0);
        chk("g_req", {31'd0, mem_req_o}, 32'd1);
        chk("g_addr", mem_addr_o, 32'h44);
        idle_n(3);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 32'h0, 0, 1);
            chk("p_vld", {31'd0, ins_vld_o}, 32'd1);
            chk("p_stall", {31'd0, stall_o}, 32'd1);
        end
        step(0, 0, 32'h0, 0, 0);
        chk("p_ins", ins_o, 32'h1234_5678);
        step(0, 0, 32'h0, 0, 0);
        chk("p_done", {31'd0, ins_vld_o}, 32'd0);
        gnt_wait = 0;

        // flush while waiting for the response
        lat = 4; rdat = 32'hDEAD_BEEF;
        step(0, 1, 32'h20, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 1, 0);
        step(0, 1, 32'h80, 0, 0);
        step(0, 1, 32'h80, 0, 0);
        step(0, 1, 32'h80, 0, 0);
        lat = 1;
        step(0, 1, 32'h80, 0, 0);
        chk("f_req", {31'd0, mem_req_o}, 32'd0);
        chk("f_vld", {31'd0, ins_vld_o}, 32'd0);
        step(0, 0, 32'h0, 0, 0);
        chk("f_req2", {31'd0, mem_req_o}, 32'd1);
        chk("f_addr", mem_addr_o, 32'h80);
        idle_n(3);

        // misaligned PC
        step(0, 1, 32'h42, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        chk("m_err", {31'd0, err_o}, 32'd1);
        chk("m_req", {31'd0, mem_req_o}, 32'd0);
        step(0, 0, 32'h0, 0, 0);
        chk("m_err2", {31'd0, err_o}, 32'd0);
        chk("m_vld", {31'd0, ins_vld_o}, 32'd0);

        // timeout, then late response dropped
        lat = 20;
        step(0, 1, 32'h100, 0, 0);
        idle_n(9);
        step(0, 0, 32'h0, 0, 0);
        chk("t_err", {31'd0, err_o}, 32'd1);
        chk("t_req", {31'd0, mem_req_o}, 32'd0);
        step(0, 0, 32'h0, 0, 0);
        chk("t_err2", {31'd0, err_o}, 32'd0);
        step(0, 1, 32'h200, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        chk("t_drop", {31'd0, mem_req_o}, 32'd0);
        idle_n(8);
        lat = 1;
        step(0, 1, 32'h300, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        chk("t_req3", {31'd0, mem_req_o}, 32'd1);
        chk("t_addr", mem_addr_o, 32'h300);
        idle_n(4);

        // back-to-back, reset during second fetch
        rdat = 32'hA5A5_0001;
        step(0, 1, 32'h0, 0, 0);
        idle_n(2);
        step(0, 1, 32'h4, 0, 0);
        chk("bb_vld", {31'd0, ins_vld_o}, 32'd1);
        chk("bb_pc", ins_pc_o, 32'h0);
        step(0, 0, 32'h0, 0, 0);
        step(1, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        chk("r_req", {31'd0, mem_req_o}, 32'd0);
        chk("r_addr", mem_addr_o, 32'h0);
        chk("r_ins", ins_o, 32'h0);
        chk("r_pc", ins_pc_o, 32'h0);
        chk("r_vld", {31'd0, ins_vld_o}, 32'd0);
        step(0, 1, 32'h0, 0, 0);
        idle_n(2);
        step(0, 1, 32'h4, 0, 0);
        chk("bb1", {31'd0, ins_vld_o}, 32'd1);
        idle_n(2);
        step(0, 0, 32'h0, 0, 0);
        chk("bb2", {31'd0, ins_vld_o}, 32'd1);
        chk("bb2_pc", ins_pc_o, 32'h4);

        // random traffic
        rnd = 1;
        for (int i = 0; i < 4000; i++) begin
            pc = $urandom;
            if ($urandom_range(0, 9) != 0) pc[1:0] = 2'b00;
            else if (pc[1:0] == 2'b00) pc[0] = 1'b1;
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 9) < 6, pc,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 2) == 0);
        end
        step(0, 0, 32'h0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
